// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and
// request legality decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_e;

  // Stores only have signed-less B/H/W; loads add the unsigned variants.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

  // f3[1:0] carries the access size for every legal code.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the word-wide dataMemory bus.
interface lsu_if #(
  parameter int ADDR_BITS = 5,
  parameter int XLEN      = 32
);
  logic                 reqValid;
  logic                 reqReady;
  logic                 reqIsStore;
  logic [2:0]           reqFunct3;
  logic [XLEN-1:0]      reqAddr;
  logic [XLEN-1:0]      reqStoreData;
  logic                 done;
  logic                 err;
  logic [XLEN-1:0]      loadData;
  logic                 memRead;
  logic                 memWrite;
  logic [ADDR_BITS-1:0] memAddress;
  logic [XLEN-1:0]      memWriteData;
  logic [XLEN-1:0]      memReadData;

  modport master (
    output reqValid, reqIsStore, reqFunct3, reqAddr, reqStoreData, memReadData,
    input  reqReady, done, err, loadData, memRead, memWrite, memAddress, memWriteData
  );

  modport slave (
    input  reqValid, reqIsStore, reqFunct3, reqAddr, reqStoreData, memReadData,
    output reqReady, done, err, loadData, memRead, memWrite, memAddress, memWriteData
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: extends the addressed lane of a read word for loads and
// splices store bytes into it for sub-word read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_word >> {i_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merge = i_word;
    if (i_funct3 == F3_B)
      o_merge[{i_lo, 3'b000} +: 8] = i_sdata[7:0];
    else if (i_funct3 == F3_H)
      o_merge[{i_lo[1], 4'b0000} +: 16] = i_sdata[15:0];
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one core request becomes dataMemory read, write or
// read-modify-write cycles, finishing with a one-cycle done pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS = 5,
  parameter int XLEN      = 32
) (
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);
  lsu_state_e           r_state;
  logic                 r_store;
  logic [2:0]           r_f3;
  logic [1:0]           r_lo;
  logic [XLEN-1:0]      r_sdata;
  logic                 r_err;
  logic [XLEN-1:0]      r_load;
  logic [ADDR_BITS-1:0] r_maddr;
  logic [XLEN-1:0]      r_wdata;   // doubles as the RMW merge register

  logic [XLEN-1:0]      w_load;
  logic [XLEN-1:0]      w_merge;
  logic                 w_bad;
  logic                 w_unused;

  assign w_bad    = f3_illegal(bus.reqIsStore, bus.reqFunct3) ||
                    misaligned(bus.reqFunct3, bus.reqAddr[1:0]);
  assign w_unused = ^bus.reqAddr[XLEN-1:ADDR_BITS+2];

  lsu_align u_align (
    .i_word   (bus.memReadData),
    .i_lo     (r_lo),
    .i_funct3 (r_f3),
    .i_sdata  (r_sdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_store <= 1'b0;
      r_f3    <= 3'd0;
      r_lo    <= 2'd0;
      r_sdata <= '0;
      r_err   <= 1'b0;
      r_load  <= '0;
      r_maddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.reqValid) begin
          r_store <= bus.reqIsStore;
          r_f3    <= bus.reqFunct3;
          r_lo    <= bus.reqAddr[1:0];
          r_sdata <= bus.reqStoreData;
          r_maddr <= bus.reqAddr[ADDR_BITS+1:2];
          r_err   <= w_bad;
          if (w_bad) begin
            r_state <= RESP;
          end else if (bus.reqIsStore && bus.reqFunct3 == F3_W) begin
            r_wdata <= bus.reqStoreData;
            r_state <= WR;
          end else begin
            r_state <= RD;
          end
        end
        RD:  r_state <= RDW;
        RDW: begin
          if (r_store) begin
            r_wdata <= w_merge;
            r_state <= WR;
          end else begin
            r_load  <= w_load;
            r_state <= RESP;
          end
        end
        WR:      r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes are state decodes so an async reset removes them immediately.
  assign bus.reqReady     = (r_state == IDLE);
  assign bus.memRead      = (r_state == RD);
  assign bus.memWrite     = (r_state == WR);
  assign bus.done         = (r_state == RESP);
  assign bus.err          = (r_state == RESP) && r_err;
  assign bus.loadData     = r_load;
  assign bus.memAddress   = r_maddr;
  assign bus.memWriteData = r_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-word memory model, a stimulus
// process that queues expected responses, and a monitor that checks done pulses.
module tb_load_store_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  lsu_if #(.ADDR_BITS(5), .XLEN(32)) bus ();

  load_store_unit #(.ADDR_BITS(5), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic        preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      mem[3] <= 32'h80FF7F01;
    end else begin
      if (bus.memWrite) mem[bus.memAddress] <= bus.memWriteData;
      if (bus.memRead)  bus.memReadData <= mem[bus.memAddress];
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] ld;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_ld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("resp_err", {31'd0, bus.err}, {31'd0, x.err});
        check("resp_loadData", bus.loadData, x.ld);
      end
    end
  end

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit e, input logic [31:0] ld,
                       input int lat, input logic [31:0] wd);
    exp_t x;
    int   n, cyc, nrd, nwr, rdc, wrc;
    bit   got;
    if (!st && !e) last_ld = ld;
    x.err = e;
    x.ld  = last_ld;
    sb.push_back(x);
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqIsStore = st; bus.reqFunct3 = f3;
    bus.reqAddr = a; bus.reqStoreData = d;
    n = 0;
    while (!bus.reqReady && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    cyc = 0; nrd = 0; nwr = 0; rdc = 0; wrc = 0; got = 0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      if (bus.memRead) begin nrd++; rdc = cyc; end
      if (bus.memWrite) begin
        nwr++; wrc = cyc;
        check("wr_addr", {27'd0, bus.memAddress}, {27'd0, a[6:2]});
        check("wr_data", bus.memWriteData, wd);
      end
      if (bus.memRead && bus.memWrite) check("rd_wr_both", 32'd1, 32'd0);
      if (bus.done) got = 1;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    check("latency", cyc, lat);
    check("n_memRead", nrd, (e || (st && f3 == 3'b010)) ? 0 : 1);
    check("n_memWrite", nwr, (st && !e) ? 1 : 0);
    if (nrd == 1 && nwr == 1) check("rmw_spacing", wrc - rdc, 2);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; last_ld = 32'd0;
    preload = 1'b1;
    reset = 1'b0;
    bus.reqValid = 1'b1; bus.reqIsStore = 1'b0; bus.reqFunct3 = 3'b010;
    bus.reqAddr = 32'h8; bus.reqStoreData = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_memRead", {31'd0, bus.memRead}, 32'd0);
    check("rst_memWrite", {31'd0, bus.memWrite}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_loadData", bus.loadData, 32'd0);
    check("rst_memAddress", {27'd0, bus.memAddress}, 32'd0);
    bus.reqValid = 1'b0;
    preload = 1'b0;
    reset = 1'b1;
    #1 check("rst_reqReady", {31'd0, bus.reqReady}, 32'd1);

    issue(1, 3'b010, 32'h08, 32'hDEADBEEF, 0, 0, 2, 32'hDEADBEEF);
    issue(0, 3'b010, 32'h08, 0, 0, 32'hDEADBEEF, 3, 0);
    issue(0, 3'b000, 32'h0D, 0, 0, 32'h0000007F, 3, 0);
    issue(0, 3'b000, 32'h0E, 0, 0, 32'hFFFFFFFF, 3, 0);
    issue(0, 3'b100, 32'h0F, 0, 0, 32'h00000080, 3, 0);
    issue(0, 3'b001, 32'h0E, 0, 0, 32'hFFFF80FF, 3, 0);
    issue(0, 3'b101, 32'h0C, 0, 0, 32'h00007F01, 3, 0);
    issue(1, 3'b000, 32'h0D, 32'h123456AA, 0, 0, 4, 32'h80FFAA01);
    issue(0, 3'b010, 32'h0C, 0, 0, 32'h80FFAA01, 3, 0);
    issue(1, 3'b001, 32'h0E, 32'hFFFF1234, 0, 0, 4, 32'h1234AA01);
    issue(0, 3'b010, 32'h0C, 0, 0, 32'h1234AA01, 3, 0);
    issue(0, 3'b101, 32'h0E, 0, 0, 32'h00001234, 3, 0);
    issue(0, 3'b010, 32'h8C, 0, 0, 32'h1234AA01, 3, 0);
    issue(0, 3'b010, 32'h0A, 0, 1, 0, 1, 0);
    issue(1, 3'b001, 32'h05, 32'h5555, 1, 0, 1, 0);
    issue(0, 3'b011, 32'h08, 0, 1, 0, 1, 0);
    issue(1, 3'b100, 32'h08, 32'h1, 1, 0, 1, 0);

    // Abort an SB in its write cycle.
    @(negedge clk);
    bus.reqValid = 1'b1; bus.reqIsStore = 1'b1; bus.reqFunct3 = 3'b000;
    bus.reqAddr = 32'h10; bus.reqStoreData = 32'h77;
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pre_memWrite", {31'd0, bus.memWrite}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_memWrite", {31'd0, bus.memWrite}, 32'd0);
    check("abort_memRead", {31'd0, bus.memRead}, 32'd0);
    check("abort_reqReady", {31'd0, bus.reqReady}, 32'd1);
    check("abort_loadData", bus.loadData, 32'd0);
    last_ld = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    issue(0, 3'b010, 32'h08, 0, 0, 32'hDEADBEEF, 3, 0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
